mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal on the shared memory port arbiter apart from clk/rst.
//   slave  : the arbiter's view (requests and memory read data in; grants,
//            responses and memory command out)
//   master : the view of the requesters plus memory array (the mirror image)
// Requester side : dbg_lock, req_*/we_*/addr_*/wdata_* in; gnt_*, rvalid_*, rdata out
// Memory side    : mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
// Status         : busy (read in flight), last_gnt (0=F, 1=D, 2=G)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 19
);
    logic              dbg_lock;
    logic              req_f, req_d, req_g;
    logic              we_f, we_d, we_g;
    logic [ADDR_W-1:0] addr_f, addr_d, addr_g;
    logic [DATA_W-1:0] wdata_f, wdata_d, wdata_g;
    logic              gnt_f, gnt_d, gnt_g;
    logic              rvalid_f, rvalid_d, rvalid_g;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [1:0]        last_gnt;

    modport slave (
        input  dbg_lock,
        input  req_f, req_d, req_g,
        input  we_f, we_d, we_g,
        input  addr_f, addr_d, addr_g,
        input  wdata_f, wdata_d, wdata_g,
        input  mem_rdata,
        output gnt_f, gnt_d, gnt_g,
        output rvalid_f, rvalid_d, rvalid_g,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, last_gnt
    );

    modport master (
        output dbg_lock,
        output req_f, req_d, req_g,
        output we_f, we_d, we_g,
        output addr_f, addr_d, addr_g,
        output wdata_f, wdata_d, wdata_g,
        output mem_rdata,
        input  gnt_f, gnt_d, gnt_g,
        input  rvalid_f, rvalid_d, rvalid_g,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, last_gnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-RAM port between instruction fetch (F), load/store (D)
// and debug/program loader (G). One command per grant, round-robin priority
// starting after the last winner, dbg_lock restricts the port to G. Reads park
// the arbiter in WAIT for RD_LAT cycles; the data-return cycle is also an
// arbitration cycle, so reads can issue back-to-back every RD_LAT cycles and
// writes every cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (requests, grants, read responses,
//              memory command/data, busy and last_gnt status)
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    logic [0:0]        state;
    logic [2:0]        rd_cnt;
    logic [1:0]        owner;
    logic [1:0]        last_gnt_q;

    logic [2:0]        elig;       // {G, D, F}
    logic [1:0]        win_idx;
    logic              rsp_cycle;
    logic              arb_live;
    logic              grant;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    always_comb begin
        elig      = {bus.req_g, bus.req_d & ~bus.dbg_lock, bus.req_f & ~bus.dbg_lock};
        // Read data is on mem_rdata in the last WAIT cycle; the port is free again then.
        rsp_cycle = (state == S_WAIT) && (rd_cnt == 3'd1);
        arb_live  = ~rst && ((state == S_IDLE) || rsp_cycle);

        // Search order begins with the requester after the previous winner.
        win_idx = 2'd0;
        case (last_gnt_q)
            2'd0: begin
                if (elig[1])      win_idx = 2'd1;
                else if (elig[2]) win_idx = 2'd2;
                else              win_idx = 2'd0;
            end
            2'd1: begin
                if (elig[2])      win_idx = 2'd2;
                else if (elig[0]) win_idx = 2'd0;
                else              win_idx = 2'd1;
            end
            default: begin
                if (elig[0])      win_idx = 2'd0;
                else if (elig[1]) win_idx = 2'd1;
                else              win_idx = 2'd2;
            end
        endcase
        grant = arb_live && (elig != 3'b000);

        case (win_idx)
            2'd0: begin
                win_we    = bus.we_f;
                win_addr  = bus.addr_f;
                win_wdata = bus.wdata_f;
            end
            2'd1: begin
                win_we    = bus.we_d;
                win_addr  = bus.addr_d;
                win_wdata = bus.wdata_d;
            end
            default: begin
                win_we    = bus.we_g;
                win_addr  = bus.addr_g;
                win_wdata = bus.wdata_g;
            end
        endcase
    end

    assign bus.gnt_f     = grant && (win_idx == 2'd0);
    assign bus.gnt_d     = grant && (win_idx == 2'd1);
    assign bus.gnt_g     = grant && (win_idx == 2'd2);
    assign bus.rvalid_f  = ~rst && rsp_cycle && (owner == 2'd0);
    assign bus.rvalid_d  = ~rst && rsp_cycle && (owner == 2'd1);
    assign bus.rvalid_g  = ~rst && rsp_cycle && (owner == 2'd2);
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = grant;
    assign bus.mem_we    = grant && win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;
    assign bus.busy      = ~rst && (state == S_WAIT);
    assign bus.last_gnt  = last_gnt_q;

    // Command issue / read-latency sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_cnt     <= 3'd0;
            owner      <= 2'd0;
            last_gnt_q <= 2'd2;
        end else begin
            if (grant) begin
                last_gnt_q <= win_idx;
            end
            if (grant && !win_we) begin
                state  <= S_WAIT;
                rd_cnt <= LAT_INIT;
                owner  <= win_idx;
            end else if (state == S_WAIT) begin
                if (rd_cnt <= 3'd1) begin
                    state  <= S_IDLE;
                    rd_cnt <= 3'd0;
                end else begin
                    rd_cnt <= rd_cnt - 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: synchronous RAM with RD_LAT read pipeline on the
// memory side, directed scenarios with literal expectations, then randomized
// requesters checked every cycle against a timestamp-based port model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 19;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory array: write at the command edge, read data LAT cycles later.
    logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe [0:LAT-1];
    assign bus.mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : DATA_W'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The port is described by the cycle number from which it may be granted
    // again, and at most one outstanding read with its return cycle and data.
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    int                next_free = 0;
    bit                pend_v    = 0;
    int                pend_ret  = 0;
    int                pend_own  = 0;
    logic [DATA_W-1:0] pend_data = '0;
    int                m_last    = 2;

    function automatic logic m_we(input int w);
        return (w == 0) ? bus.we_f : (w == 1) ? bus.we_d : bus.we_g;
    endfunction
    function automatic logic [ADDR_W-1:0] m_addr(input int w);
        return (w == 0) ? bus.addr_f : (w == 1) ? bus.addr_d : bus.addr_g;
    endfunction
    function automatic logic [DATA_W-1:0] m_wdata(input int w);
        return (w == 0) ? bus.wdata_f : (w == 1) ? bus.wdata_d : bus.wdata_g;
    endfunction

    always @(negedge clk) begin
        logic [2:0] e, eg, er;
        bit         g;
        int         w;
        int         c;
        e  = {bus.req_g, bus.req_d && !bus.dbg_lock, bus.req_f && !bus.dbg_lock};
        g  = 0;
        w  = 0;
        eg = 3'b000;
        er = 3'b000;
        if (!rst && cyc >= next_free) begin
            for (int k = 1; k <= 3; k++) begin
                c = (m_last + k) % 3;
                if (!g && e[c]) begin
                    g = 1;
                    w = c;
                end
            end
        end
        if (g) eg[w] = 1'b1;
        if (!rst && pend_v && pend_ret == cyc) er[pend_own] = 1'b1;

        chk("gnt", 32'({bus.gnt_g, bus.gnt_d, bus.gnt_f}), 32'(eg));
        chk("rvalid", 32'({bus.rvalid_g, bus.rvalid_d, bus.rvalid_f}), 32'(er));
        if (er != 3'b000) chk("rdata", 32'(bus.rdata), 32'(pend_data));
        chk("mem_en", 32'(bus.mem_en), 32'(g));
        if (g) begin
            chk("mem_we", 32'(bus.mem_we), 32'(m_we(w)));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr(w)));
            if (m_we(w)) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata(w)));
        end
        chk("busy", 32'(bus.busy), 32'(!rst && pend_v));
        chk("last_gnt", 32'(bus.last_gnt), 32'(m_last));

        // state after the coming clock edge
        if (rst) begin
            pend_v    = 0;
            next_free = 0;
            m_last    = 2;
        end else begin
            if (pend_v && pend_ret == cyc) pend_v = 0;
            if (g) begin
                m_last = w;
                if (m_we(w)) begin
                    shadow[m_addr(w)] = m_wdata(w);
                    next_free = cyc + 1;
                end else begin
                    pend_v    = 1;
                    pend_ret  = cyc + LAT;
                    pend_own  = w;
                    pend_data = shadow[m_addr(w)];
                    next_free = cyc + LAT;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive_req(input int x, input logic r, input logic we,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        case (x)
            0: begin bus.req_f = r; bus.we_f = we; bus.addr_f = a; bus.wdata_f = d; end
            1: begin bus.req_d = r; bus.we_d = we; bus.addr_d = a; bus.wdata_d = d; end
            default: begin bus.req_g = r; bus.we_g = we; bus.addr_g = a; bus.wdata_g = d; end
        endcase
    endtask

    function automatic logic cur_req(input int x);
        return (x == 0) ? bus.req_f : (x == 1) ? bus.req_d : bus.req_g;
    endfunction

    task automatic clear_reqs();
        for (int x = 0; x < 3; x++) drive_req(x, 1'b0, 1'b0, '0, '0);
        bus.dbg_lock = 1'b0;
    endtask

    // Leaves the bench just after a clock edge with rst low: the caller drives cycle 0.
    task automatic do_reset(input int n);
        tick();
        rst = 1'b1;
        clear_reqs();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] gvec();
        return {bus.gnt_g, bus.gnt_d, bus.gnt_f};
    endfunction
    function automatic logic [2:0] rvec();
        return {bus.rvalid_g, bus.rvalid_d, bus.rvalid_f};
    endfunction

    logic [2:0] order [0:3];
    logic [2:0] prev_g;
    logic [2:0] exp_g, exp_r;

    initial begin
        clear_reqs();
        rst = 1'b1;

        // reset state
        at_neg();
        chk("rst_gnt", 32'(gvec()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_last_gnt", 32'(bus.last_gnt), 32'd2);

        // preload words 0..31 through G writes, word 5 = 0x1A2B3
        do_reset(2);
        for (int a = 0; a < 32; a++) begin
            if (a > 0) tick();
            drive_req(2, 1'b1, 1'b1, ADDR_W'(a), (a == 5) ? DATA_W'(19'h1A2B3) : DATA_W'($urandom));
            at_neg();
            chk("preload_gnt", 32'(gvec()), 32'b100);
        end
        tick();
        clear_reqs();

        // single F read of word 5
        do_reset(2);
        drive_req(0, 1'b1, 1'b0, 10'h005, '0);
        at_neg();
        chk("rd1_gnt", 32'(gvec()), 32'b001);
        chk("rd1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("rd1_mem_addr", 32'(bus.mem_addr), 32'h005);
        chk("rd1_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rd1_busy0", 32'(bus.busy), 32'd0);
        tick();
        clear_reqs();
        for (int i = 1; i < LAT; i++) begin
            if (i > 1) tick();
            at_neg();
            chk("rd1_wait_busy", 32'(bus.busy), 32'd1);
            chk("rd1_wait_rvalid", 32'(rvec()), 32'd0);
            chk("rd1_wait_en", 32'(bus.mem_en), 32'd0);
        end
        tick();
        at_neg();
        chk("rd1_rvalid", 32'(rvec()), 32'b001);
        chk("rd1_rdata", 32'(bus.rdata), 32'h1A2B3);
        chk("rd1_busy_last", 32'(bus.busy), 32'd1);
        tick();
        at_neg();
        chk("rd1_idle_busy", 32'(bus.busy), 32'd0);
        chk("rd1_idle_rvalid", 32'(rvec()), 32'd0);

        // all three read continuously: F, D, G, F, each returning LAT cycles later
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        do_reset(2);
        drive_req(0, 1'b1, 1'b0, 10'h001, '0);
        drive_req(1, 1'b1, 1'b0, 10'h002, '0);
        drive_req(2, 1'b1, 1'b0, 10'h003, '0);
        for (int i = 0; i < 4 * LAT; i++) begin
            if (i > 0) tick();
            at_neg();
            exp_g = (i % LAT == 0) ? order[i / LAT] : 3'b000;
            exp_r = (i >= LAT && (i - LAT) % LAT == 0) ? order[(i - LAT) / LAT] : 3'b000;
            chk("rr_rd_gnt", 32'(gvec()), 32'(exp_g));
            chk("rr_rd_rvalid", 32'(rvec()), 32'(exp_r));
        end
        tick();
        clear_reqs();

        // F and D write continuously: alternate every cycle, port never busy
        do_reset(2);
        drive_req(0, 1'b1, 1'b1, 10'h014, 19'h11111);
        drive_req(1, 1'b1, 1'b1, 10'h015, 19'h22222);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            at_neg();
            chk("wr_alt_gnt", 32'(gvec()), (i % 2 == 0) ? 32'b001 : 32'b010);
            chk("wr_alt_we", 32'(bus.mem_we), 32'd1);
            chk("wr_alt_busy", 32'(bus.busy), 32'd0);
        end
        tick();
        clear_reqs();

        // dbg_lock: only G, then F resumes round-robin after G
        do_reset(2);
        bus.dbg_lock = 1'b1;
        drive_req(0, 1'b1, 1'b1, 10'h016, 19'h33333);
        drive_req(1, 1'b1, 1'b1, 10'h017, 19'h44444);
        drive_req(2, 1'b1, 1'b1, 10'h018, 19'h55555);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            at_neg();
            chk("lock_gnt", 32'(gvec()), 32'b100);
        end
        tick();
        bus.dbg_lock = 1'b0;
        drive_req(2, 1'b0, 1'b0, '0, '0);
        at_neg();
        chk("unlock_last_gnt", 32'(bus.last_gnt), 32'd2);
        chk("unlock_gnt", 32'(gvec()), 32'b001);
        tick();
        clear_reqs();

        // reset while a D read is in flight: response dropped
        do_reset(2);
        drive_req(1, 1'b1, 1'b0, 10'h007, '0);
        at_neg();
        chk("rstw_gnt", 32'(gvec()), 32'b010);
        tick();
        drive_req(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        at_neg();
        chk("rstw_rvalid_in_rst", 32'(rvec()), 32'd0);
        chk("rstw_busy_in_rst", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (i > 0) tick();
            at_neg();
            chk("rstw_rvalid_after", 32'(rvec()), 32'd0);
            chk("rstw_busy_after", 32'(bus.busy), 32'd0);
            chk("rstw_last_gnt", 32'(bus.last_gnt), 32'd2);
        end
        tick();
        drive_req(0, 1'b1, 1'b0, 10'h001, '0);
        drive_req(1, 1'b1, 1'b0, 10'h002, '0);
        drive_req(2, 1'b1, 1'b0, 10'h003, '0);
        at_neg();
        chk("rstw_first_gnt", 32'(gvec()), 32'b001);
        tick();
        clear_reqs();

        // D writes 0x00042 to 0x010, G reads it back in the next cycle
        do_reset(2);
        repeat (LAT) tick();
        drive_req(1, 1'b1, 1'b1, 10'h010, 19'h00042);
        at_neg();
        chk("raw_wr_gnt", 32'(gvec()), 32'b010);
        tick();
        drive_req(1, 1'b0, 1'b0, '0, '0);
        drive_req(2, 1'b1, 1'b0, 10'h010, '0);
        at_neg();
        chk("raw_rd_gnt", 32'(gvec()), 32'b100);
        tick();
        drive_req(2, 1'b0, 1'b0, '0, '0);
        for (int i = 1; i < LAT; i++) begin
            if (i > 1) tick();
            at_neg();
            chk("raw_wait_rvalid", 32'(rvec()), 32'd0);
        end
        tick();
        at_neg();
        chk("raw_rvalid", 32'(rvec()), 32'b100);
        chk("raw_rdata", 32'(bus.rdata), 32'h00042);
        tick();
        clear_reqs();

        // randomized requesters, occasional dbg_lock toggles and resets
        do_reset(2);
        prev_g = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) tick();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) bus.dbg_lock = ~bus.dbg_lock;
            for (int x = 0; x < 3; x++) begin
                if (!cur_req(x) || prev_g[x]) begin
                    if ($urandom_range(0, 3) != 0)
                        drive_req(x, 1'b1, 1'($urandom_range(0, 1)),
                                  ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
                    else
                        drive_req(x, 1'b0, 1'b0, '0, '0);
                end
            end
            at_neg();
            prev_g = gvec();
        end
        tick();
        rst = 1'b0;
        clear_reqs();
        repeat (LAT + 2) tick();
        at_neg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
